block_sdec192: RTL

BLOCK_SDEC192 -- requirements
Module: block_sdec192

---
 rtl/block_sdec192.sv | 159 +++++++++++++++
 1 files changed

// File: rtl/block_sdec192.sv
// FM stereo MPX decoder: integrate-and-dump demodulation of L+R, (L-R) and pilot
// over 2^DEC_LOG2 samples, with a pilot lock FSM gating stereo separation.
module block_sdec192 #(
    parameter int DEC_LOG2 = 3,
    parameter int PILOT_TH = 2048,
    parameter int LOCK_CNT = 4,
    parameter int LOSS_CNT = 2
) (
    input  logic               clock,
    input  logic               reset,
    input  logic signed [17:0] mpx_in,
    input  logic               mpx_valid,
    input  logic signed [9:0]  DDS_F19,
    input  logic signed [9:0]  DDS_F38,
    output logic signed [17:0] left_out,
    output logic signed [17:0] right_out,
    output logic               out_valid,
    output logic               pilot_lock,
    output logic               ovf
);

    typedef enum logic [1:0] {SEARCH, CONFIRM, LOCKED} state_t;

    state_t                state, state_nx;
    logic [2:0]            fcnt, fcnt_nx;
    logic [3:0]            fcnt_inc;
    logic [DEC_LOG2-1:0]   smp_cnt;
    logic signed [31:0]    acc_s, acc_d, acc_p;
    logic signed [27:0]    prod38, prod19;
    logic signed [31:0]    term_s, term_d, term_p;
    logic signed [31:0]    sum_s, sum_d, sum_p;
    logic signed [31:0]    s_val, d_val, p_val;
    logic signed [32:0]    l_half, r_half;
    logic                  dump, hit;
    logic                  clip_l, clip_r;

    function automatic logic signed [17:0] sat18(input logic signed [32:0] v);
        if (v > 33'sd131071)
            return 18'sh1FFFF;
        else if (v < -33'sd131072)
            return 18'sh20000;
        else
            return v[17:0];
    endfunction

    assign prod38 = 28'(mpx_in) * 28'(DDS_F38);
    assign prod19 = 28'(mpx_in) * 28'(DDS_F19);
    assign term_s = 32'(mpx_in);
    assign term_d = 32'(prod38) >>> 8;
    assign term_p = 32'(prod19) >>> 9;

    assign sum_s = acc_s + term_s;
    assign sum_d = acc_d + term_d;
    assign sum_p = acc_p + term_p;

    assign dump  = mpx_valid && (smp_cnt == '1);
    assign s_val = sum_s >>> DEC_LOG2;
    assign p_val = sum_p >>> DEC_LOG2;
    // Stereo term gated by the lock state held before this dump's FSM update
    assign d_val = pilot_lock ? (sum_d >>> DEC_LOG2) : '0;
    assign hit   = (p_val >= PILOT_TH);

    assign l_half = (33'(s_val) + 33'(d_val)) >>> 1;
    assign r_half = (33'(s_val) - 33'(d_val)) >>> 1;
    assign clip_l = (l_half > 33'sd131071) || (l_half < -33'sd131072);
    assign clip_r = (r_half > 33'sd131071) || (r_half < -33'sd131072);

    assign pilot_lock = (state == LOCKED);
    assign fcnt_inc   = {1'b0, fcnt} + 4'd1;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state <= SEARCH;
            fcnt  <= '0;
        end else begin
            state <= state_nx;
            fcnt  <= fcnt_nx;
        end
    end

    always_comb begin
        state_nx = state;
        fcnt_nx  = fcnt;
        if (dump) begin
            unique case (state)
                SEARCH: begin
                    if (hit) begin
                        if (LOCK_CNT <= 1) begin
                            state_nx = LOCKED;
                            fcnt_nx  = '0;
                        end else begin
                            state_nx = CONFIRM;
                            fcnt_nx  = 3'd1;
                        end
                    end
                end
                CONFIRM: begin
                    if (!hit) begin
                        state_nx = SEARCH;
                        fcnt_nx  = '0;
                    end else if (fcnt_inc == 4'(LOCK_CNT)) begin
                        state_nx = LOCKED;
                        fcnt_nx  = '0;
                    end else begin
                        fcnt_nx  = fcnt_inc[2:0];
                    end
                end
                LOCKED: begin
                    if (hit) begin
                        fcnt_nx  = '0;
                    end else if (fcnt_inc == 4'(LOSS_CNT)) begin
                        state_nx = SEARCH;
                        fcnt_nx  = '0;
                    end else begin
                        fcnt_nx  = fcnt_inc[2:0];
                    end
                end
                default: begin
                    state_nx = SEARCH;
                    fcnt_nx  = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            acc_s     <= '0;
            acc_d     <= '0;
            acc_p     <= '0;
            smp_cnt   <= '0;
            left_out  <= '0;
            right_out <= '0;
            out_valid <= 1'b0;
            ovf       <= 1'b0;
        end else begin
            out_valid <= 1'b0;
            if (mpx_valid) begin
                if (dump) begin
                    acc_s     <= '0;
                    acc_d     <= '0;
                    acc_p     <= '0;
                    smp_cnt   <= '0;
                    left_out  <= sat18(l_half);
                    right_out <= sat18(r_half);
                    out_valid <= 1'b1;
                    if (clip_l || clip_r)
                        ovf <= 1'b1;
                end else begin
                    acc_s   <= sum_s;
                    acc_d   <= sum_d;
                    acc_p   <= sum_p;
                    smp_cnt <= smp_cnt + 1'b1;
                end
            end
        end
    end

endmodule
